clk_div_ctrl: RTL
=================

// Module: clk_div_ctrl
// PURPOSE
//  Programmable integer clock divider feeding the generated-clock hierarchy.
//  Derives a divided clock from clk_in with divisor D and registered edge strobes.
//  Divisor changes are glitch-free; start/stop happen only at period boundaries.
//  Sits directly upstream of the clock generator stage; drives its divided clock input.
// PARAMETERS
//  CNT_W        8   width of divisor and internal period counter
//  DEFAULT_DIV  2   divisor loaded at reset; must be >= 2
// PORTS
//  clk_in            in   1      single clock, all logic on posedge
//  rst_in            in   1      synchronous, active-high reset
//  en_in             in   1      level enable: run divider when high
//  div_ratio_in      in   CNT_W  requested divisor D
//  div_load_in       in   1      1-cycle strobe: capture div_ratio_in as pending divisor
//  div_load_ack_out  out  1      1-cycle pulse when a pending divisor becomes active
//  div_err_out       out  1      sticky: a load with div_ratio_in < 2 was clamped to 2
//  clk_div_out       out  1      divided clock, registered
//  clk_div_rise_out  out  1      1-cycle pulse, same cycle clk_div_out goes 0->1
//  clk_div_fall_out  out  1      1-cycle pulse, same cycle clk_div_out goes 1->0
//  running_out       out  1      high in RUN and STOP_PEND
// BEHAVIOUR
//  Reset
//   - state=IDLE, cnt=0, active D=DEFAULT_DIV, no pending divisor.
//   - All outputs 0.
//   - Reset mid-period aborts immediately; any pending load is discarded.
//  Period
//   - Period is D cycles; cnt runs 0..D-1.
//   - clk_div_out=1 while cnt < (D>>1), else 0.
//   - D=2: 1 high / 1 low. D=3: 1 high / 2 low. D=255: 127 high / 128 low.
//  FSM states
//   - IDLE: clk_div_out=0.
//     en_in=1 at edge -> RUN; cnt<=0; clk_div_out<=1; clk_div_rise_out<=1.
//     Latency: 1 cycle from en_in sampled to first high.
//   - RUN: each edge, if cnt!=D-1 then cnt<=cnt+1.
//     Boundary (cnt==D-1): cnt<=0; apply pending divisor; clk_div_out<=1; rise pulse.
//     en_in=0 sampled in RUN -> STOP_PEND; the current period still completes.
//   - STOP_PEND: counts as in RUN.
//     en_in=1 -> back to RUN, with no change to counting.
//     At boundary with en_in=0 -> IDLE; clk_div_out<=0; no rise pulse.
//     Pending divisor is applied at that boundary.
//  Divisor loading
//   - div_load_in is accepted in any state except reset.
//   - Value is clamped to 2 if < 2; a clamp sets div_err_out (cleared only by rst_in).
//   - Held as pending; a second load before application overwrites it (last wins).
//   - Load in IDLE takes effect immediately: active D updated, ack pulses next cycle.
//   - In RUN/STOP_PEND, pending is applied only at the boundary edge, with
//     div_load_ack_out=1 on that edge.
//   - Load on the same edge as a boundary is not applied that boundary; it is
//     applied at the next boundary.
//  Strobe and counter rules
//   - Rise/fall strobes are registered alongside clk_div_out; never both in one cycle.
//   - Counter compare uses full CNT_W width; cnt never exceeds D-1.
// TESTING
//  1 Reset D=2, en_in=1 held:
//    clk_div_out 1,0,1,0...; rise every 2 cycles; first high 1 cycle after en_in.
//  2 Load 5 in IDLE, then enable:
//    ack next cycle; period 5 (2 high / 3 low); rise pulses 5 cycles apart.
//  3 Running D=4, load 6 at cnt=1:
//    current period stays 4 cycles; ack at boundary; next periods 6 cycles (3/3).
//  4 Load 7 then 3 before the boundary in RUN:
//    only 3 is applied; single ack pulse.
//  5 Drop en_in at cnt=0 with D=6:
//    period completes (3 high / 3 low); IDLE; clk_div_out stays 0; running_out falls.
//  6 Load 0 -> D=2 with div_err_out=1 (sticky).
//    Assert rst_in mid-high phase -> next cycle all outputs 0 and err cleared.

Source files
------------

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Programmable integer clock divider. Produces a registered
//               divided clock of period D (high for D>>1 cycles) together with
//               registered rise/fall strobes. Divisor updates are held pending
//               and applied only at a period boundary, so the output never
//               glitches; start and stop also occur only at period boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic [CNT_W-1:0] div_ratio_in,
  input  logic             div_load_in,
  output logic             div_load_ack_out,
  output logic             div_err_out,
  output logic             clk_div_out,
  output logic             clk_div_rise_out,
  output logic             clk_div_fall_out,
  output logic             running_out
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  // A divisor below 2 cannot produce a clock; refuse to elaborate.
  if (DEFAULT_DIV < 2) begin : g_bad_default_div
    $error("clk_div_ctrl: DEFAULT_DIV must be >= 2");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             run_q, run_d;

  logic             load_bad;
  logic [CNT_W-1:0] load_val;
  logic             at_bound;
  logic [CNT_W-1:0] cnt_step;
  logic             clk_step;

  // Clamp incoming divisor and derive the free-running count step.
  always_comb begin
    load_bad = (div_ratio_in < C_MIN_DIV);
    load_val = load_bad ? C_MIN_DIV : div_ratio_in;
    // >= rather than == keeps the counter bounded even if it were ever
    // left above D-1; in normal operation the two are equivalent.
    at_bound = (cnt_q >= (div_q - C_ONE));
    cnt_step = at_bound ? '0 : (cnt_q + C_ONE);
    // Count 0 is always in the high phase because D>>1 is at least 1.
    clk_step = (cnt_step < (div_q >> 1));
  end

  // Next-state logic for the divider FSM, divisor bookkeeping and strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    clk_d      = clk_q;
    ack_d      = 1'b0;
    err_d      = err_q | (div_load_in & load_bad);

    case (state_q)
      ST_IDLE: begin
        clk_d = 1'b0;
        cnt_d = '0;
        // No period is in flight, so a divisor can be adopted right away.
        // A fresh load wins over anything left pending from the stop edge.
        if (div_load_in) begin
          div_d      = load_val;
          ack_d      = 1'b1;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          div_d      = pend_div_q;
          ack_d      = 1'b1;
          pend_vld_d = 1'b0;
        end
        if (en_in) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          clk_d   = 1'b1;
        end
      end

      ST_RUN, ST_STOP_PEND: begin
        cnt_d = cnt_step;
        clk_d = clk_step;
        if (at_bound) begin
          // Period complete: the previously pending divisor takes effect.
          if (pend_vld_q) begin
            div_d      = pend_div_q;
            ack_d      = 1'b1;
            pend_vld_d = 1'b0;
          end
          if (en_in) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
            clk_d   = 1'b0;
          end
        end else begin
          state_d = en_in ? ST_RUN : ST_STOP_PEND;
        end
        // Captured after the boundary apply so a load on the boundary edge
        // waits for the following boundary.
        if (div_load_in) begin
          pend_div_d = load_val;
          pend_vld_d = 1'b1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        clk_d      = 1'b0;
        pend_vld_d = 1'b0;
      end
    endcase

    rise_d = clk_d & ~clk_q;
    fall_d = ~clk_d & clk_q;
    run_d  = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= C_RST_DIV;
      pend_div_q <= C_RST_DIV;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      run_q      <= run_d;
    end
  end

  assign clk_div_out      = clk_q;
  assign clk_div_rise_out = rise_q;
  assign clk_div_fall_out = fall_q;
  assign div_load_ack_out = ack_q;
  assign div_err_out      = err_q;
  assign running_out      = run_q;

endmodule
`default_nettype wire
